uart_serial_port: RTL and testbench

Serial-port peripheral on the far end of the processor's byte-wide serial interface. Presents received UART bytes to the processor through a valid/read-enable handshake, and accepts bytes from the processor through a ready/write-enable handshake for UART transmission. Contains:
- a UART receiver feeding a small RX FIFO;
- a single-buffer UART transmitter.

Sits between the board UART pins and the processor's serial_* ports.

---
 rtl/uart_serial_defs.sv | 24 ++
 rtl/uart_rx_fifo.sv | 64 ++++++
 rtl/uart_serial_port.sv | 210 +++++++++++++++++++++
 tb/tb_uart_serial_port.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_serial_defs.sv
// Shared constants and FSM state encodings for uart_serial_port.
// Optional parity support is enabled by defining UART_PARITY_EN.
package uart_serial_defs;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] RX_PARITY = 3'd3;
`endif
  localparam logic [2:0] RX_STOP   = 3'd4;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] TX_PARITY = 3'd3;
`endif
  localparam logic [2:0] TX_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO buffering received bytes; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: storage is cleared on reset so the head byte reads 0x00 afterwards.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_serial_port.sv
// UART serial port: RX FSM feeding uart_rx_fifo, single-buffer TX FSM.
// Define UART_PARITY_EN to add an even-parity bit to both directions.
module uart_serial_port
  import uart_serial_defs::*;
#(
  parameter int CLKS_PER_BIT  = 16,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_rden_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  output logic       rx_error_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_err_q, rx_err_d;
  logic                 rx_push, rx_frame_err, rx_full, rx_empty, rx_par_ok;

  logic [2:0]           tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_line_q, tx_line_d;

`ifdef UART_PARITY_EN
  logic rx_par_q, rx_par_d, tx_par_q, tx_par_d;
  assign rx_par_ok = ~^{rx_shift_q, rx_par_q};
`else
  assign rx_par_ok = 1'b1;
`endif

  assign uart_tx_out  = tx_line_q;
  assign tx_ready_out = (tx_state_q == TX_IDLE);
  assign rx_valid_out = ~rx_empty;
  assign rx_error_out = rx_err_q;

  uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift_q),
    .pop       (rx_rden_in),
    .head      (rx_data_out),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Receiver: every sample point is a whole bit period after the mid-start resample.
  always_comb begin
    rx_meta_d    = uart_rx_in;
    rx_sync_d    = rx_meta_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + 1'b1;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_push      = 1'b0;
    rx_frame_err = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d     = rx_par_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_sync_q != LINE_IDLE) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = (rx_sync_q == LINE_IDLE) ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        rx_idx_d   = rx_idx_q + 1'b1;
`ifdef UART_PARITY_EN
        if (rx_idx_q == IDX_LAST) rx_state_d = RX_PARITY;
`else
        if (rx_idx_q == IDX_LAST) rx_state_d = RX_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_par_d   = rx_sync_q;
        rx_state_d = RX_STOP;
      end
`endif
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_push      = (rx_sync_q == LINE_IDLE) & rx_par_ok;
        rx_frame_err = ~rx_push;
        rx_state_d   = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    rx_err_d = rx_frame_err | (rx_push & rx_full & ~rx_rden_in);
  end

  // Transmitter: tx_line_q is updated on the edge that starts each bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_wren_in) begin
          tx_shift_d = tx_data_in;
          tx_idx_d   = '0;
          tx_line_d  = ~LINE_IDLE;
          tx_state_d = TX_START;
`ifdef UART_PARITY_EN
          tx_par_d   = ^tx_data_in;
`endif
        end
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_line_d  = tx_shift_q[0];
        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
          tx_line_d  = tx_par_q;
          tx_state_d = TX_PARITY;
`else
          tx_line_d  = LINE_IDLE;
          tx_state_d = TX_STOP;
`endif
        end else begin
          tx_idx_d   = tx_idx_q + 1'b1;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_line_d  = LINE_IDLE;
        tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: if (tx_cnt_q == BIT_LAST) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q  <= LINE_IDLE;
      rx_sync_q  <= LINE_IDLE;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_err_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= LINE_IDLE;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      tx_par_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_err_q   <= rx_err_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
      tx_par_q   <= tx_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_serial_port.sv
// Directed bench for uart_serial_port with a frame-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_uart_serial_port;

  localparam int C     = 16;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 11 : 10;

  logic       clock = 1'b0, reset = 1'b1;
  logic       uart_rx_in = 1'b1, rx_rden_in = 1'b0, tx_wren_in = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       uart_tx_out, rx_valid_out, tx_ready_out, rx_error_out;
  logic [7:0] rx_data_out;

  uart_serial_port #(.CLKS_PER_BIT(C), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .uart_rx_in   (uart_rx_in),
    .uart_tx_out  (uart_tx_out),
    .rx_data_out  (rx_data_out),
    .rx_valid_out (rx_valid_out),
    .rx_rden_in   (rx_rden_in),
    .tx_data_in   (tx_data_in),
    .tx_wren_in   (tx_wren_in),
    .tx_ready_out (tx_ready_out),
    .rx_error_out (rx_error_out)
  );

  always #5 clock = ~clock;

  int         n_vec = 0, n_bad = 0, cyc = 0;
  bit         chk_en = 1'b0, rx_quiet = 1'b1;
  int         err_cycles = 0, exp_err = 0;
  logic [7:0] rxq[$];
  bit         m_tx_act = 1'b0, m_rdy;
  int         m_tx_acc = 0;
  logic [7:0] m_tx_byte = 8'h00;
  int         exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line level d cycles after the accept edge: bit k = d / C of the frame.
  function automatic logic exp_tx(input int c);
    int d, k;
    if (!m_tx_act) return 1'b1;
    d = c - m_tx_acc;
    if (d >= NB * C) return 1'b1;
    k = d / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_tx_byte[k-1];
    if (PAR && k == 9) return ^m_tx_byte;
    return 1'b1;
  endfunction

  function automatic logic exp_ready(input int c);
    return !m_tx_act || (c - m_tx_acc >= NB * C);
  endfunction

  always @(posedge clock) begin
    m_rdy = exp_ready(cyc);
    cyc++;
    if (reset) begin
      m_tx_act = 1'b0;
      rxq.delete();
    end else if (tx_wren_in && m_rdy) begin
      m_tx_act  = 1'b1;
      m_tx_acc  = cyc;
      m_tx_byte = tx_data_in;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("tx_line", uart_tx_out, exp_tx(cyc));
      check("tx_ready", tx_ready_out, exp_ready(cyc));
      if (rx_quiet) begin
        check("rx_valid", rx_valid_out, rxq.size() != 0);
        if (rxq.size() != 0) check("rx_data", rx_data_out, rxq[0]);
      end
      if (rx_error_out === 1'b1) err_cycles++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rx_in = v;
    step(C);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_b, input bit bad_par,
                            input bit pop_mid);
    rx_quiet   = 1'b0;
    uart_rx_in = 1'b0;
    if (pop_mid) begin
      rx_rden_in = 1'b1;
      step(1);
      rx_rden_in = 1'b0;
      if (rxq.size() != 0) void'(rxq.pop_front());
      step(C - 1);
    end else begin
      step(C);
    end
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit((^b) ^ bad_par);
    drive_bit(stop_b);
    uart_rx_in = 1'b1;
    step(C);
    if (!stop_b || (PAR && bad_par)) exp_err++;
    else if (rxq.size() < DEPTH) rxq.push_back(b);
    else exp_err++;
    rx_quiet = 1'b1;
    check("rx_err_count", err_cycles, exp_err);
  endtask

  task automatic pop_rx();
    rx_rden_in = 1'b1;
    step(1);
    rx_rden_in = 1'b0;
    if (rxq.size() != 0) void'(rxq.pop_front());
  endtask

  task automatic tx_send(input logic [7:0] b);
    tx_data_in = b;
    tx_wren_in = 1'b1;
    step(1);
    tx_wren_in = 1'b0;
  endtask

  task automatic wait_tx_ready();
    int g = 0;
    while (tx_ready_out !== 1'b1 && g < 1000) begin
      step(1);
      g++;
    end
    check("tx_ready_timeout", g < 1000, 1);
  endtask

  initial begin
    int d;
    step(3);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_tx_line", uart_tx_out, 1);
    check("rst_tx_ready", tx_ready_out, 1);
    check("rst_rx_valid", rx_valid_out, 0);
    check("rst_rx_data", rx_data_out, 8'h00);
    check("rst_rx_error", rx_error_out, 0);

    // TX 0xA5: bit centres sampled by hand, then accept-to-ready interval.
    step(5);
    tx_send(8'hA5);
    step(C / 2);
    check("tx_a5_start", uart_tx_out, 0);
    for (int i = 0; i < 8; i++) begin
      step(C);
      check($sformatf("tx_a5_bit%0d", i), uart_tx_out, exp_a5[i]);
    end
    d = C / 2 + 8 * C;
    if (PAR) begin
      step(C);
      d += C;
      check("tx_a5_parity", uart_tx_out, 0);
    end
    step(C);
    d += C;
    check("tx_a5_stop", uart_tx_out, 1);
    while (tx_ready_out !== 1'b1 && d < 400) begin
      step(1);
      d++;
    end
    check("tx_accept_to_ready", d, PAR ? 176 : 160);

    // Back-to-back accept, then a write while busy must be ignored.
    tx_send(8'h3C);
    step(40);
    tx_send(8'hFF);
    wait_tx_ready();

    // RX single byte, then reads with and without data.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check("rx_3c_valid", rx_valid_out, 1);
    check("rx_3c_data", rx_data_out, 8'h3C);
    pop_rx();
    check("rx_3c_popped", rx_valid_out, 0);
    pop_rx();
    check("rx_pop_empty", rx_valid_out, 0);

    // Overflow: fifth byte dropped with a single error pulse.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    check("ovf_err_pulses", err_cycles, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_read%0d", i), rx_data_out, 8'(i + 1));
      pop_rx();
    end
    check("ovf_drained", rx_valid_out, 0);

    // Full FIFO with a pop before the next push: no drop.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
    send_frame(8'h14, 1'b1, 1'b0, 1'b1);
    check("full_pop_no_err", err_cycles, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_pop_read%0d", i), rx_data_out, 8'h11 + 8'(i));
      pop_rx();
    end

    // Framing error and false start.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check("frame_err_pulses", err_cycles, 2);
    check("frame_err_empty", rx_valid_out, 0);
    uart_rx_in = 1'b0;
    step(4);
    uart_rx_in = 1'b1;
    step(2 * C);
    check("glitch_no_err", err_cycles, 2);
    check("glitch_no_push", rx_valid_out, 0);

    // Reset during TX data bit 3 with two bytes buffered.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    tx_send(8'h5A);
    step(4 * C + 4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_tx_line", uart_tx_out, 1);
    check("midrst_tx_ready", tx_ready_out, 1);
    check("midrst_rx_valid", rx_valid_out, 0);
    check("midrst_rx_data", rx_data_out, 8'h00);
    send_frame(8'h99, 1'b1, 1'b0, 1'b0);
    check("post_rst_data", rx_data_out, 8'h99);
    pop_rx();

    if (PAR) begin
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      check("par_bad_empty", rx_valid_out, 0);
      tx_send(8'h07);
      step(9 * C + C / 2);
      check("tx_07_parity", uart_tx_out, 1);
      wait_tx_ready();
    end

    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
